// File: rtl/plate_pkg.sv
// Shared types, defaults and helpers for the plate manager block.
package plate_pkg;
    localparam int          DEF_N_PLATES  = 6;
    localparam int          DEF_SPACING   = 80;
    localparam int          DEF_BASE_Y    = 16;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    localparam int PLATE_W = 64;
    localparam int X_BASE  = PLATE_W;
    localparam int X_STEP  = 80;
    localparam int X_MIN   = 32;
    localparam int COORD_W = 20;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        SCAN,
        DONE
    } state_e;

    // World coordinates clamp at the top of the 20-bit range instead of wrapping.
    function automatic coord_t sat_add(coord_t a, coord_t b);
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_W] ? '1 : sum[COORD_W-1:0];
    endfunction
endpackage

// File: rtl/plate_manager_if.sv
// Frame request / plate placement bundle between the frame controller and the plate manager.
interface plate_manager_if #(
    parameter int N_PLATES = plate_pkg::DEF_N_PLATES
);
    import plate_pkg::*;

    logic                         frame;
    logic [7:0]                   scroll_amt;
    coord_t                       screen_height;
    logic [N_PLATES*COORD_W-1:0]  plate_x_init;
    logic [N_PLATES*COORD_W-1:0]  plate_y_init;
    logic                         busy;
    logic                         done;
    logic                         overrun;

    modport master (
        output frame, scroll_amt,
        input  screen_height, plate_x_init, plate_y_init, busy, done, overrun
    );

    modport slave (
        input  frame, scroll_amt,
        output screen_height, plate_x_init, plate_y_init, busy, done, overrun
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick respawn X positions.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end
endmodule

// File: rtl/plate_manager.sv
// Per-frame plate update: scroll the screen, then recycle plates that fell below it to the top.
module plate_manager
    import plate_pkg::*;
#(
    parameter int          N_PLATES  = DEF_N_PLATES,
    parameter int          SPACING   = DEF_SPACING,
    parameter int          BASE_Y    = DEF_BASE_Y,
    parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic clk,
    input  logic rst,
    plate_manager_if.slave bus
);
    localparam int IDX_W = (N_PLATES > 1) ? $clog2(N_PLATES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLATES - 1);

    state_e           state_q;
    logic [7:0]       amt_q;
    coord_t           screen_height_q;
    coord_t           top_y_q;
    coord_t           x_q [N_PLATES];
    coord_t           y_q [N_PLATES];
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic [15:0]      lfsr_q;
    logic [6:0]       lfsr_unused;
    coord_t           cur_y;
    logic             respawn;
    coord_t           new_top_d;
    coord_t           new_x_d;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr_q)
    );

    // Only the low nine LFSR bits shape the X position.
    assign lfsr_unused = lfsr_q[15:9];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cur_y = '0;
        for (int i = 0; i < N_PLATES; i++) begin
            if (idx_q == IDX_W'(i)) cur_y = y_q[i];
        end
        respawn   = (state_q == SCAN) && (cur_y < screen_height_q);
        new_top_d = sat_add(top_y_q, coord_t'(SPACING));
        new_x_d   = coord_t'(lfsr_q[8:0]) + coord_t'(X_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            amt_q           <= '0;
            screen_height_q <= '0;
            top_y_q         <= coord_t'(BASE_Y + (N_PLATES - 1) * SPACING);
            idx_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            overrun_q       <= 1'b0;
            // NOTE: the plate arrays are live state with defined start positions, so they are reset like any flop.
            for (int i = 0; i < N_PLATES; i++) begin
                y_q[i] <= coord_t'(BASE_Y + i * SPACING);
                x_q[i] <= coord_t'(X_BASE + i * X_STEP);
            end
        end else begin
            done_q <= 1'b0;
            if (bus.frame && (state_q != IDLE)) overrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.frame) begin
                        amt_q   <= bus.scroll_amt;
                        busy_q  <= 1'b1;
                        state_q <= SCROLL;
                    end
                end
                SCROLL: begin
                    screen_height_q <= sat_add(screen_height_q, coord_t'(amt_q));
                    idx_q           <= '0;
                    state_q         <= SCAN;
                end
                SCAN: begin
                    // Respawns chain through top_y so several in one scan stack upward.
                    if (respawn) top_y_q <= new_top_d;
                    for (int i = 0; i < N_PLATES; i++) begin
                        if (respawn && (idx_q == IDX_W'(i))) begin
                            y_q[i] <= new_top_d;
                            x_q[i] <= new_x_d;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.screen_height = screen_height_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overrun       = overrun_q;

    always_comb begin
        bus.plate_x_init = '0;
        bus.plate_y_init = '0;
        for (int i = 0; i < N_PLATES; i++) begin
            bus.plate_x_init[i*COORD_W +: COORD_W] = x_q[i];
            bus.plate_y_init[i*COORD_W +: COORD_W] = y_q[i];
        end
    end
endmodule

// File: tb/tb_plate_manager.sv
// Randomized scoreboard bench for plate_manager against a frame-level reference model.
module tb_plate_manager;
    localparam int          NP   = 6;
    localparam int          SP   = 80;
    localparam int          BY   = 16;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          SAT  = 'hFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plate_manager_if #(.N_PLATES(NP)) bus ();

    plate_manager #(
        .N_PLATES  (NP),
        .SPACING   (SP),
        .BASE_Y    (BY),
        .LFSR_SEED (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int     sh;
        int     x [NP];
        int     y [NP];
        bit     ovr;
        longint done_edge;
    } exp_t;

    exp_t   sb_q [$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint ecount = 0;
    int     nedge = 0;

    int m_sh, m_top;
    int m_x [NP];
    int m_y [NP];
    bit m_ovr;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s;
        s = SEED;
        repeat (n) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_reset();
        m_sh  = 0;
        m_top = BY + (NP - 1) * SP;
        m_ovr = 1'b0;
        for (int i = 0; i < NP; i++) begin
            m_y[i] = BY + i * SP;
            m_x[i] = 64 + i * 80;
        end
    endtask

    // Monitor: counts edges and checks every done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            ecount++;
            if (rst) nedge = 0;
            else     nedge++;
            #1;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_edge", ecount, e.done_edge);
                    check("screen_height", bus.screen_height, e.sh);
                    check("overrun", bus.overrun, e.ovr);
                    for (int i = 0; i < NP; i++) begin
                        check($sformatf("plate_y[%0d]", i), bus.plate_y_init[i*20 +: 20], e.y[i]);
                        check($sformatf("plate_x[%0d]", i), bus.plate_x_init[i*20 +: 20], e.x[i]);
                    end
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_screen_height", bus.screen_height, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_overrun", bus.overrun, 0);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("rst_plate_y[%0d]", i), bus.plate_y_init[i*20 +: 20], BY + i * SP);
            check($sformatf("rst_plate_x[%0d]", i), bus.plate_x_init[i*20 +: 20], 64 + i * 80);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.frame = 1'b0;
        sb_q.delete();
        model_reset();
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
    endtask

    // Issues one accepted frame (plus an optional ignored one) and returns once the DUT is idle.
    task automatic do_frame(input int amt, input bit extra, input int gap);
        exp_t        e;
        logic [15:0] l;
        @(negedge clk);
        bus.frame      = 1'b1;
        bus.scroll_amt = amt[7:0];

        m_sh = sat(m_sh + amt);
        for (int i = 0; i < NP; i++) begin
            if (m_y[i] < m_sh) begin
                m_top  = sat(m_top + SP);
                m_y[i] = m_top;
                l      = lfsr_at(nedge + 2 + i);
                m_x[i] = int'(l[8:0]) + 32;
            end
        end
        if (extra) m_ovr = 1'b1;
        e.sh        = m_sh;
        e.x         = m_x;
        e.y         = m_y;
        e.ovr       = m_ovr;
        e.done_edge = ecount + 3 + NP;
        sb_q.push_back(e);

        @(negedge clk);
        bus.frame      = extra;
        bus.scroll_amt = 8'hFF;
        @(negedge clk);
        bus.frame = 1'b0;
        check("sh_next_cycle", bus.screen_height, m_sh);
        check("busy_during_update", bus.busy, 1);
        repeat (NP + 1 + gap) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xv;
        bus.frame      = 1'b0;
        bus.scroll_amt = '0;
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset();
        repeat (3) @(negedge clk);
        check_reset_values();

        // Small scroll: no plate crosses the screen bottom.
        do_frame(10, 1'b0, 0);
        // Second scroll reaches 20: plate 0 recycles to the top.
        do_frame(10, 1'b0, 1);
        check("plate0_respawn_y", bus.plate_y_init[19:0], 496);
        xv = int'(bus.plate_x_init[19:0]);
        check("plate0_x_in_range", (xv >= 32 && xv <= 543) ? 1 : 0, 1);

        // One large scroll recycles two plates, stacked.
        apply_reset();
        do_frame(100, 1'b0, 0);
        check("plate0_stack_y", bus.plate_y_init[19:0], 496);
        check("plate1_stack_y", bus.plate_y_init[39:20], 576);

        // Frame while busy is ignored and overrun stays sticky.
        apply_reset();
        do_frame(30, 1'b1, 0);
        check("overrun_set", bus.overrun, 1);
        do_frame(5, 1'b0, 2);
        check("overrun_sticky", bus.overrun, 1);

        // Reset during the scan abandons the update, then the LFSR restarts from its seed.
        apply_reset();
        @(negedge clk);
        bus.frame      = 1'b1;
        bus.scroll_amt = 8'd100;
        @(negedge clk);
        bus.frame = 1'b0;
        repeat (3) @(negedge clk);
        apply_reset();
        repeat (NP + 4) @(negedge clk);
        check("idle_after_abort", bus.busy, 0);
        do_frame(100, 1'b0, 0);

        // Randomized frames with occasional ignored pulses.
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            do_frame(int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk);
        check("pending_expectations", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/plate_manager.md
PLATE_MANAGER -- requirements
Module: plate_manager

Interface
REQ-001 Parameter N_PLATES, default 6, number of plates managed.
REQ-002 Parameter SPACING, default 80, world-Y gap between successive plates.
REQ-003 Parameter BASE_Y, default 16, world-Y of plate 0 after reset.
REQ-004 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; never zero.
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 frame  in  1  one-cycle pulse at start of vertical blank.
REQ-008 scroll_amt  in  8  world-Y rise requested this frame; sampled only on an accepted frame.
REQ-009 screen_height  out  20  world-Y of screen bottom; feeds every plate sprite stage.
REQ-010 plate_x_init  out  N_PLATES x 20, packed  per-plate screen X.
REQ-011 plate_y_init  out  N_PLATES x 20, packed  per-plate world Y.
REQ-012 busy  out  1  high while an update is in progress.
REQ-013 done  out  1  one-cycle pulse when the update completes.
REQ-014 overrun  out  1  sticky; set when a frame pulse is ignored.

Function
REQ-015 FSM states SHALL be IDLE, SCROLL, SCAN, DONE.
REQ-016 IDLE + frame=1 -> SCROLL and latch scroll_amt; IDLE + frame=0 -> stay in IDLE.
REQ-017 SCROLL (1 cycle): screen_height += latched amount, saturating at 20'hFFFFF; scan index <= 0; -> SCAN.
REQ-018 SCAN: one plate per cycle, ascending index; after index N_PLATES-1 -> DONE.
REQ-019 Respawn condition: plate_y_init[i] < screen_height (plate has fallen below the screen bottom).
REQ-020 On respawn: plate_y_init[i] <= top_y + SPACING, saturating at 20'hFFFFF; top_y <= the same value in the same cycle, so several respawns in one scan stack upward.
REQ-021 On respawn: plate_x_init[i] <= {11'b0, lfsr[8:0]} + 32, so X lies in 32..543.
REQ-022 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting every cycle except while rst is asserted.
REQ-023 DONE (1 cycle): done=1 -> IDLE; busy=1 in SCROLL, SCAN and DONE, 0 in IDLE.
REQ-024 Latency: frame accepted at edge t -> screen_height updates at t+1, done is high during cycle t+2+N_PLATES.
REQ-025 A frame pulse in any state other than IDLE SHALL be ignored and SHALL set overrun; only rst clears overrun.
REQ-026 Plates not meeting REQ-019 SHALL hold X and Y unchanged.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On rst: state=IDLE, screen_height=0, busy=0, done=0, overrun=0, lfsr=LFSR_SEED.
REQ-029 On rst: plate_y_init[i]=BASE_Y+i*SPACING, plate_x_init[i]=64+i*80, top_y=BASE_Y+(N_PLATES-1)*SPACING.
REQ-030 rst asserted mid-update SHALL abandon the update; reset values apply at the next edge, with no done pulse.

Structure
REQ-031 Package plate_pkg SHALL hold: N_PLATES/SPACING/BASE_Y/LFSR_SEED defaults, PLATE_W=64, the state enum, and the 20-bit coordinate typedef.
REQ-032 Sub-module lfsr16 SHALL hold the LFSR, with ports clk, rst, en, q[15:0]; no other sub-modules.

Verification
REQ-033 Reset then idle: screen_height=0; plate_y_init = 16,96,176,256,336,416; plate_x_init = 64,144,...,464; busy=0.
REQ-034 frame with scroll_amt=10 -> screen_height=10 one cycle later; no respawn; done pulses exactly 8 cycles after the frame edge.
REQ-035 Repeated frames totalling scroll of 20 -> plate 0 (y=16) respawns to y=496, X in 32..543; top_y=496.
REQ-036 Scroll totalling 100 in one frame -> plates 0 and 1 respawn to y=496 and y=576 respectively.
REQ-037 Second frame pulse while busy -> ignored, screen_height changes once, overrun=1 until rst.
REQ-038 rst asserted during SCAN -> all reset values at the next edge, no done pulse; LFSR sequence restarts from 16'hACE1.
